// File: rtl/fpall_pkg.sv
// Shared types for the fpall floating-point slice: operand format, operation and the
// tagged response record carried through the issue controller's response FIFO.
package fpall_pkg;

  typedef enum logic [1:0] {
    FP32 = 2'd0,
    FP16 = 2'd1,
    BF16 = 2'd2
  } fp_fmt_e;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1
  } fp_op_e;

  localparam int unsigned TagW = 4;

  typedef struct packed {
    logic [31:0]     r;
    logic [TagW-1:0] tag;
  } fp_rsp_t;

endpackage

// File: rtl/fpall_rsp_fifo.sv
// Circular response buffer of fp_rsp_t; simultaneous push and pop are allowed at any fill.
// The caller's credit scheme guarantees no push into a full FIFO without a matching pop.
module fpall_rsp_fifo
  import fpall_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  fp_rsp_t push_data,
  input  logic    pop,
  output logic    valid,
  output fp_rsp_t head
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]   count_q, count_d;
  fp_rsp_t         mem_q [DEPTH];
  fp_rsp_t         mem_d [DEPTH];
  logic            full, pop_ok;

  assign valid  = count_q != '0;
  assign full   = count_q == (PtrW+1)'(DEPTH);
  assign pop_ok = pop && valid;
  assign head   = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = count_q + {{PtrW{1'b0}}, push} - {{PtrW{1'b0}}, pop_ok};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  push_when_full_a : assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop));

endmodule

// File: rtl/fpall_shared.sv
// Free-running fixed-latency FP32 add/sub unit: R reflects the operands LAT edges later.
// Operands are treated as normal-or-zero (subnormals flush to zero); no handshake, no reset.
module fpall_shared
  import fpall_pkg::*;
#(
  parameter int unsigned LAT = 2
) (
  input  logic        clk,
  input  fp_fmt_e     fmt,
  input  fp_op_e      op,
  input  logic [31:0] x,
  input  logic [31:0] y,
  output logic [31:0] r
);

  function automatic logic [31:0] fp32_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] big, sml;
    logic [26:0] mb, ms, ms_sh, m;
    logic [27:0] sum;
    logic [7:0]  d;
    logic [9:0]  e;
    logic [4:0]  lz;
    logic        found, up;
    logic [24:0] rnd;
    if (a[30:0] >= b[30:0]) begin
      big = a;
      sml = b;
    end else begin
      big = b;
      sml = a;
    end
    mb = (|big[30:23]) ? {1'b1, big[22:0], 3'b000} : 27'd0;
    ms = (|sml[30:23]) ? {1'b1, sml[22:0], 3'b000} : 27'd0;
    d  = big[30:23] - sml[30:23];
    // Alignment keeps guard/round bits plus a sticky OR of everything shifted out.
    if (d > 8'd26) ms_sh = {26'd0, |ms};
    else ms_sh = (ms >> d) | {26'd0, |(ms & ((27'd1 << d) - 27'd1))};
    e = {2'b00, big[30:23]};
    if (big[31] == sml[31]) begin
      sum = {1'b0, mb} + {1'b0, ms_sh};
      if (sum[27]) begin
        m = sum[27:1] | {26'd0, sum[0]};
        e = e + 10'd1;
      end else begin
        m = sum[26:0];
      end
      if (m == 27'd0) return {big[31], 31'd0};
    end else begin
      m = mb - ms_sh;
      if (m == 27'd0) return 32'd0;
      lz    = 5'd0;
      found = 1'b0;
      for (int i = 26; i >= 0; i--) begin
        if (!found) begin
          if (m[i]) found = 1'b1;
          else lz = lz + 5'd1;
        end
      end
      m = m << lz;
      e = e - {5'd0, lz};
    end
    up  = m[2] & (m[1] | m[0] | m[3]);
    rnd = {1'b0, m[26:3]} + {24'd0, up};
    if (rnd[24]) begin
      rnd = rnd >> 1;
      e   = e + 10'd1;
    end
    if (e[9] || e == 10'd0) return {big[31], 31'd0};
    if (e >= 10'd255) return {big[31], 8'hff, 23'd0};
    return {big[31], e[7:0], rnd[22:0]};
  endfunction

  logic [31:0] y_eff, res;
  logic [31:0] pipe_q [LAT];

  always_comb begin
    y_eff = y;
    if (op == OP_SUB) y_eff[31] = ~y[31];
    res = (fmt == FP32) ? fp32_add(x, y_eff) : 32'h7fc0_0000;
  end

  always_ff @(posedge clk) begin
    pipe_q[0] <= res;
    for (int i = 1; i < int'(LAT); i++) pipe_q[i] <= pipe_q[i-1];
  end

  assign r = pipe_q[LAT-1];

endmodule

// File: rtl/fpall_issue_ctrl.sv
// Valid/ready front end for fpall_shared: captures operands, tracks in-flight tags in a
// shift pipe and retires results in order into a credit-protected response FIFO.
module fpall_issue_ctrl
  import fpall_pkg::*;
#(
  parameter int unsigned LAT   = 2,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = TagW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  fp_fmt_e          req_fmt,
  input  fp_op_e           req_op,
  input  logic [31:0]      req_x,
  input  logic [31:0]      req_y,
  input  logic [TAG_W-1:0] req_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_r,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic             accept, pop, push;
  logic [CntW-1:0]  credits_q, credits_d;
  fp_fmt_e          fmt_q, fmt_d;
  fp_op_e           op_q, op_d;
  logic [31:0]      x_q, x_d, y_q, y_d, shared_r;
  logic [LAT:0]     vpipe_q, vpipe_d;
  logic [TAG_W-1:0] tagpipe_q [LAT+1];
  logic [TAG_W-1:0] tagpipe_d [LAT+1];
  fp_rsp_t          push_data, head;

  // Admission depends on registered credits only, so a pop frees a slot one cycle later.
  assign req_ready = credits_q < CntW'(DEPTH);
  assign accept    = req_valid && req_ready;
  assign pop       = rsp_valid && rsp_ready;
  assign push      = vpipe_q[LAT];
  assign busy      = credits_q != '0;
  assign push_data = '{r: shared_r, tag: tagpipe_q[LAT]};
  assign rsp_r     = head.r;
  assign rsp_tag   = head.tag;

  always_comb begin
    fmt_d = fmt_q;
    op_d  = op_q;
    x_d   = x_q;
    y_d   = y_q;
    if (accept) begin
      fmt_d = req_fmt;
      op_d  = req_op;
      x_d   = req_x;
      y_d   = req_y;
    end
    vpipe_d      = {vpipe_q[LAT-1:0], accept};
    tagpipe_d[0] = accept ? req_tag : tagpipe_q[0];
    for (int i = 1; i <= int'(LAT); i++) tagpipe_d[i] = tagpipe_q[i-1];
    credits_d = credits_q + {{(CntW-1){1'b0}}, accept} - {{(CntW-1){1'b0}}, pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fmt_q     <= FP32;
      op_q      <= OP_ADD;
      x_q       <= '0;
      y_q       <= '0;
      vpipe_q   <= '0;
      credits_q <= '0;
      for (int i = 0; i <= int'(LAT); i++) tagpipe_q[i] <= '0;
    end else begin
      fmt_q     <= fmt_d;
      op_q      <= op_d;
      x_q       <= x_d;
      y_q       <= y_d;
      vpipe_q   <= vpipe_d;
      credits_q <= credits_d;
      tagpipe_q <= tagpipe_d;
    end
  end

  fpall_shared #(
    .LAT(LAT)
  ) u_shared (
    .clk(clk),
    .fmt(fmt_q),
    .op (op_q),
    .x  (x_q),
    .y  (y_q),
    .r  (shared_r)
  );

  fpall_rsp_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_data(push_data),
    .pop      (pop),
    .valid    (rsp_valid),
    .head     (head)
  );

endmodule

// File: tb/tb_fpall_issue_ctrl.sv
// Scoreboard bench for fpall_issue_ctrl: expected {r, tag} queued on accept, compared on pop.
module tb_fpall_issue_ctrl;
  import fpall_pkg::*;

  localparam int unsigned LAT = 2, DEPTH = 4, TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst_n, req_valid, req_ready, rsp_valid, rsp_ready, busy;
  fp_fmt_e          req_fmt;
  fp_op_e           req_op;
  logic [31:0]      req_x, req_y, rsp_r;
  logic [TAG_W-1:0] req_tag, rsp_tag;

  always #5 clk = ~clk;

  fpall_issue_ctrl #(
    .LAT(LAT), .DEPTH(DEPTH), .TAG_W(TAG_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_fmt(req_fmt), .req_op(req_op), .req_x(req_x), .req_y(req_y), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_r(rsp_r), .rsp_tag(rsp_tag),
    .busy(busy)
  );

  int n_tests = 0, n_fail = 0, n_acc = 0, n_pop = 0;
  logic [31+TAG_W:0] sb_q[$];
  logic [31:0]       exp_r, hold_r;
  logic [TAG_W-1:0]  hold_tag, tagc;
  logic              acc, popd, hold_q;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] f2d(input logic [31:0] f);
    if (f[30:0] == 31'd0) return {f[31], 63'd0};
    return {f[31], {3'b000, f[30:23]} + 11'd896, f[22:0], 29'd0};
  endfunction

  // Reference: exact-ish double sum rounded to single with round-to-nearest-even.
  function automatic logic [31:0] model_add(input logic [31:0] a, input logic [31:0] b);
    real         rs;
    logic [63:0] d;
    int          e;
    logic [24:0] m;
    rs = $bitstoreal(f2d(a)) + $bitstoreal(f2d(b));
    d  = $realtobits(rs);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e = int'(d[62:52]) - 896;
    m = {2'b01, d[51:29]};
    if (d[28] && ((|d[27:0]) || m[0])) m = m + 25'd1;
    if (m[24]) begin
      m = m >> 1;
      e++;
    end
    return {d[63], e[7:0], m[22:0]};
  endfunction

  function automatic logic [31:0] gen_normal();
    logic [7:0] ex;
    ex = 8'($urandom_range(100, 150));
    return {1'($urandom_range(0, 1)), ex, 23'($urandom)};
  endfunction

  task automatic set_req(input logic [TAG_W-1:0] tag);
    req_fmt = FP32;
    req_op  = OP_ADD;
    req_x   = gen_normal();
    req_y   = gen_normal();
    req_tag = tag;
    exp_r   = model_add(req_x, req_y);
  endtask

  task automatic sample();
    logic [31+TAG_W:0] e;
    @(negedge clk);
    acc  = req_valid && req_ready;
    popd = rsp_valid && rsp_ready;
    if (hold_q && rsp_valid) begin
      check_eq("hold_r", rsp_r, hold_r);
      check_eq("hold_tag", 32'(rsp_tag), 32'(hold_tag));
    end
    hold_q   = rsp_valid && !rsp_ready;
    hold_r   = rsp_r;
    hold_tag = rsp_tag;
    if (acc) begin
      sb_q.push_back({exp_r, req_tag});
      n_acc++;
    end
    if (popd) begin
      n_pop++;
      check_eq("rsp_expected", {31'd0, sb_q.size() != 0}, 32'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check_eq("rsp_r", rsp_r, e[31+TAG_W:TAG_W]);
        check_eq("rsp_tag", 32'(rsp_tag), 32'(e[TAG_W-1:0]));
      end
    end
  endtask

  task automatic step();
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input bit rnd, input int bound);
    int c = 0;
    req_valid = 1'b0;
    while ((sb_q.size() != 0 || busy) && c < bound) begin
      rsp_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      step();
      c++;
    end
    check_eq("drain_sb_empty", sb_q.size(), 0);
    check_eq("drain_idle", 32'(busy), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    int lat, first, second, a0, p0, sent, guard;
    rst_n = 1'b0; req_valid = 1'b0; req_fmt = FP32; req_op = OP_ADD;
    req_x = '0; req_y = '0; req_tag = '0; rsp_ready = 1'b0; exp_r = '0;
    hold_q = 1'b0; hold_r = '0; hold_tag = '0; tagc = '0; acc = 1'b0; popd = 1'b0;
    #12;
    check_eq("rst_rsp_valid", 32'(rsp_valid), 0);
    check_eq("rst_rsp_r", rsp_r, 0);
    check_eq("rst_rsp_tag", 32'(rsp_tag), 0);
    check_eq("rst_busy", 32'(busy), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    check_eq("rel_req_ready", 32'(req_ready), 1);

    // Single op: latency and busy fall.
    rsp_ready = 1'b1; req_valid = 1'b1;
    req_x = 32'h3f80_0000; req_y = 32'h3f80_0000; req_tag = 4'd3; exp_r = 32'h4000_0000;
    step();
    check_eq("single_acc", 32'(acc), 1);
    req_valid = 1'b0;
    lat = -1;
    for (int e = 0; e < 8 && lat < 0; e++) begin
      sample();
      if (e == 0) check_eq("busy_inflight", 32'(busy), 1);
      if (rsp_valid) lat = e;
      @(posedge clk); #1;
    end
    check_eq("single_latency", lat, 3);
    sample();
    check_eq("busy_after_pop", 32'(busy), 0);
    @(posedge clk); #1;

    // Back-to-back issue, responses on consecutive cycles.
    req_valid = 1'b1;
    req_x = 32'h3fc0_0000; req_y = 32'h4010_0000; req_tag = 4'd1; exp_r = 32'h4070_0000;
    step();
    check_eq("b2b_acc0", 32'(acc), 1);
    req_x = 32'hbf80_0000; req_y = 32'h4040_0000; req_tag = 4'd2; exp_r = 32'h4000_0000;
    step();
    check_eq("b2b_acc1", 32'(acc), 1);
    req_valid = 1'b0; first = -1; second = -1;
    for (int e = 0; e < 10; e++) begin
      sample();
      if (popd) begin
        if (first < 0) first = e;
        else if (second < 0) second = e;
      end
      @(posedge clk); #1;
    end
    check_eq("b2b_first", first, 2);
    check_eq("b2b_second", second, 3);

    // Backpressure: credit limit caps acceptance at DEPTH.
    rsp_ready = 1'b0; req_valid = 1'b1; tagc = 4'd4; set_req(tagc); a0 = n_acc;
    for (int e = 0; e < 8; e++) begin
      sample();
      @(posedge clk); #1;
      if (acc) begin tagc++; set_req(tagc); end
    end
    check_eq("bp_accepts", n_acc - a0, 4);
    check_eq("bp_ready_low", 32'(req_ready), 0);
    rsp_ready = 1'b1;
    sample();
    check_eq("bp_pop", 32'(popd), 1);
    check_eq("bp_ready_at_pop", 32'(req_ready), 0);
    @(posedge clk); #1;
    sample();
    check_eq("bp_ready_after_pop", 32'(req_ready), 1);
    check_eq("bp_acc_after_pop", 32'(acc), 1);
    @(posedge clk); #1;
    tagc++; set_req(tagc);
    guard = 0;
    while (n_acc - a0 < 6 && guard < 20) begin
      sample();
      @(posedge clk); #1;
      if (acc) begin tagc++; set_req(tagc); end
      guard++;
    end
    check_eq("bp_total_accepts", n_acc - a0, 6);
    drain(1'b0, 30);

    // FIFO at 3 with one in flight: push and pop land on the same edge.
    rsp_ready = 1'b0; p0 = n_pop;
    for (int i = 0; i < 3; i++) begin tagc++; set_req(tagc); req_valid = 1'b1; step(); end
    req_valid = 1'b0;
    repeat (4) step();
    tagc++; set_req(tagc); req_valid = 1'b1;
    step();
    check_eq("full_acc", 32'(acc), 1);
    req_valid = 1'b0;
    step(); step();
    rsp_ready = 1'b1;
    sample();
    check_eq("full_pop", 32'(popd), 1);
    check_eq("full_ready", 32'(req_ready), 0);
    @(posedge clk); #1;
    drain(1'b0, 20);
    check_eq("full_pops", n_pop - p0, 4);

    // Reset with 2 in flight and 2 buffered.
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin tagc++; set_req(tagc); req_valid = 1'b1; step(); end
    req_valid = 1'b0;
    step();
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_rsp_valid", 32'(rsp_valid), 0);
    check_eq("mid_rst_busy", 32'(busy), 0);
    sb_q.delete(); hold_q = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    rsp_ready = 1'b1;
    for (int e = 0; e < 8; e++) begin
      sample();
      check_eq("no_stale", 32'(rsp_valid), 0);
      @(posedge clk); #1;
    end
    p0 = n_pop; req_valid = 1'b1;
    req_x = 32'h3f80_0000; req_y = 32'h4000_0000; req_tag = 4'd9; exp_r = 32'h4040_0000;
    step();
    check_eq("post_rst_acc", 32'(acc), 1);
    drain(1'b0, 20);
    check_eq("post_rst_pops", n_pop - p0, 1);

    // Random normal FP32 adds with random backpressure.
    sent = 0; guard = 0; tagc = '0; set_req(tagc); req_valid = 1'b1;
    while (sent < 4000 && guard < 40000) begin
      rsp_ready = ($urandom_range(0, 1) == 1);
      sample();
      @(posedge clk); #1;
      if (acc) begin sent++; tagc++; set_req(tagc); end
      guard++;
    end
    check_eq("rand_sent", sent, 4000);
    drain(1'b1, 400);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fpall_issue_ctrl.md
Name: fpall_issue_ctrl

Overview:
- Valid/ready front end for the fixed-latency shared FP unit fpall_shared, which runs free and has no handshake.
- Accepts tagged operation requests, issues them back-to-back into fpall_shared, and tracks in-flight operations with a valid/tag shift pipe.
- Collects results in order into a small response FIFO with downstream backpressure.
- Credit-based admission guarantees the FIFO never overflows. Sits between a core/sequencer and the arithmetic datapath.

Parameters:
- LAT, 2: edges from fpall_shared operand change until R is valid; must match the instantiated unit.
- DEPTH, 4: response FIFO entries; also the in-flight + buffered credit limit; power of two, ≥2.
- TAG_W, 4: width of the request/response tag.

Ports:
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: reset, asynchronous assert, active-low.
- req_valid, input, 1: request present.
- req_ready, output, 1: request accepted when req_valid && req_ready at a rising edge.
- req_fmt, input, fp_fmt_e: operand format.
- req_op, input, fp_op_e: operation.
- req_x, input, 32: operand X.
- req_y, input, 32: operand Y.
- req_tag, input, TAG_W: opaque tag, returned with the result.
- rsp_valid, output, 1: FIFO head valid.
- rsp_ready, input, 1: consumer takes head.
- rsp_r, output, 32: result at FIFO head.
- rsp_tag, output, TAG_W: tag at FIFO head.
- busy, output, 1: any operation in flight or buffered.

Behaviour:
- Reset (rst_n=0, async): valid pipe cleared, FIFO empty, credit counter 0.
  - Outputs: req_ready=1 once released, rsp_valid=0, rsp_r=0, rsp_tag=0, busy=0.
  - Operand/format registers reset to 0 with fmt=FP32, op=OP_ADD.
  - Reset mid-operation discards all in-flight and buffered results; fpall_shared itself is unreset, and its output is ignored because the valid pipe is cleared.
- Issue:
  - On an accept at edge k, fmt/op/x/y are captured into the operand register that drives fpall_shared.
  - vpipe[0]<=1 and tagpipe[0]<=req_tag.
  - Without an accept, vpipe[0]<=0 and the operand register holds its value.
- Pipeline:
  - vpipe/tagpipe is LAT+1 entries, shifting every edge.
  - vpipe[LAT] high means fpall_shared R belongs to that entry's tag.
- Retire: when vpipe[LAT]=1, {R, tagpipe[LAT]} is pushed into the FIFO at that edge.
- Latency:
  - Accept at edge k; push at edge k+LAT+1; rsp_valid=1 in the cycle after edge k+LAT+1 if the FIFO was empty.
  - With LAT=2: accept edge 0, rsp_valid visible after edge 3.
- Throughput: one accept per cycle sustained while credit is available.
- Credit:
  - credits = in-flight count + FIFO occupancy, range 0..DEPTH.
  - Increments on accept, decrements on FIFO pop (rsp_valid && rsp_ready); both in the same edge leaves it unchanged.
  - req_ready = (credits < DEPTH), computed from registered state only; no combinational path from rsp_ready or req_valid.
  - Consequence: a pop frees a slot one cycle later.
- FIFO:
  - Circular buffer; read/write pointers of log2(DEPTH) bits wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
  - Push and pop in the same edge are allowed, including when full: count is unchanged.
  - Push when full cannot occur by construction; add an assertion for it.
  - rsp_r/rsp_tag are stable while rsp_valid=1 && rsp_ready=0.
- Ordering: responses leave strictly in accept order.
- busy = (credits != 0).
- Unsupported fmt/op values are passed through untouched; result semantics are defined by fpall_shared.

Decomposition:
- fpall_pkg (existing) supplies fp_fmt_e (FP32, ...) and fp_op_e (OP_ADD, ...).
- Add to fpall_pkg: a packed struct fp_rsp_t {r[31:0], tag}, with TAG_W as a package localparam default.
- Sub-modules:
  - fpall_shared, instantiated as the datapath.
  - fpall_rsp_fifo, a generic DEPTH-entry FIFO of fp_rsp_t, as the one natural sub-module.
- Credit counter and valid/tag pipe stay in the top.

Test Plan:
- Single op: FP32 ADD 0x3F800000+0x3F800000, tag 3, accepted at edge 0 with rsp_ready=1 → rsp_valid after edge 3, rsp_r=0x40000000, rsp_tag=3; busy falls after the pop edge.
- Back-to-back: 0x3FC00000+0x40100000 (tag 1) then 0xBF800000+0x40400000 (tag 2) on consecutive edges → responses on consecutive cycles: 0x40700000/1 then 0x40000000/2.
- Backpressure: rsp_ready=0, offer 6 requests continuously → exactly 4 accepted, req_ready=0 after the 4th accept; raise rsp_ready → 4 results in order, one new accept per pop, delayed one cycle.
- Full with simultaneous push/pop: FIFO holds 3, one in flight, rsp_ready=1 → count holds, no loss or duplication, tags stay monotonic.
- Reset mid-operation: assert rst_n=0 asynchronously with 2 in flight and 2 buffered → rsp_valid=0 immediately, busy=0, no stale result ever emerges after release; the next request returns the correct value/tag.
- Random: 4000 normal-only FP32 ADD vectors with random rsp_ready (50%) → every result matches shortreal addition bit-exactly, in order, none dropped.
